// File: rtl/rev_counter_pkg.sv
// Shared definitions for the reversible counter.
//   DIGIT_W       width of one BCD digit
//   BCD_MAX_DIGIT largest legal BCD digit value
//   bcd_sanitize  maps an illegal BCD digit (>9) to 0, passes legal digits through
package rev_counter_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

    function automatic logic [DIGIT_W-1:0] bcd_sanitize(input logic [DIGIT_W-1:0] digit);
        return (digit > BCD_MAX_DIGIT) ? '0 : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One decimal digit of the BCD up/down chain.
//   digit      in   current digit value (0..9)
//   up         in   1 = increment, 0 = decrement
//   cin        in   carry (up) or borrow (down) from the less significant digit
//   digit_next out  digit value after the step
//   cout       out  carry/borrow into the more significant digit
module bcd_digit_updown
    import rev_counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               up,
    input  logic               cin,
    output logic [DIGIT_W-1:0] digit_next,
    output logic               cout
);

    always_comb begin
        digit_next = digit;
        cout       = 1'b0;
        if (cin) begin
            if (up) begin
                if (digit == BCD_MAX_DIGIT) begin
                    digit_next = '0;
                    cout       = 1'b1;
                end else begin
                    digit_next = digit + DIGIT_W'(1);
                end
            end else begin
                if (digit == '0) begin
                    digit_next = BCD_MAX_DIGIT;
                    cout       = 1'b1;
                end else begin
                    digit_next = digit - DIGIT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rev_counter_n.sv
// Parametrised reversible (up/down) counter, binary or BCD, with parallel load,
// count enable and an internal tick prescaler (clock enable, single clock domain).
//   clk   in   system clock
//   rstn  in   synchronous active-low reset
//   en    in   count enable; low freezes counter and prescaler
//   up    in   direction: 1 = increment, 0 = decrement
//   load  in   synchronous parallel load
//   din   in   load value
//   cnt   out  current count (registered)
//   tc    out  terminal count level, combinational from cnt/up
//   rc    out  one-cycle ripple-carry pulse on each wrap (registered)
module rev_counter_n
    import rev_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter bit          BCD      = 1'b0,
    parameter int unsigned PRESCALE = 10_000_000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             rc
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    function automatic logic [WIDTH-1:0] max_value();
        logic [WIDTH-1:0] m;
        m = '1;
        if (BCD) begin
            for (int i = 0; i < int'(WIDTH / DIGIT_W); i++) begin
                m[i*DIGIT_W +: DIGIT_W] = BCD_MAX_DIGIT;
            end
        end
        return m;
    endfunction

    localparam logic [WIDTH-1:0] MAX_VAL = max_value();

    logic [WIDTH-1:0] cnt_q;
    logic             rc_q;
    logic [PS_W-1:0]  ps_q;
    logic             tick;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;
    logic             wrap;

    // With PRESCALE=1 the compare is against 0 and ps_q never leaves 0, so tick is constant 1.
    assign tick = (ps_q == PS_W'(PRESCALE - 1));

    assign tc = (up & (cnt_q == MAX_VAL)) | (~up & (cnt_q == '0));

    if (BCD) begin : g_bcd
        localparam int unsigned NDIG = WIDTH / DIGIT_W;
        logic [NDIG:0] carry;

        assign carry[0] = 1'b1;
        // Carry out of the top digit is exactly the wrap condition.
        assign wrap     = carry[NDIG];

        for (genvar i = 0; i < int'(NDIG); i++) begin : g_digit
            bcd_digit_updown u_digit (
                .digit      (cnt_q[i*DIGIT_W +: DIGIT_W]),
                .up         (up),
                .cin        (carry[i]),
                .digit_next (step_val[i*DIGIT_W +: DIGIT_W]),
                .cout       (carry[i+1])
            );
            assign load_val[i*DIGIT_W +: DIGIT_W] = bcd_sanitize(din[i*DIGIT_W +: DIGIT_W]);
        end
    end else begin : g_bin
        assign step_val = up ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
        assign load_val = din;
        assign wrap     = tc;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
            rc_q  <= 1'b0;
            ps_q  <= '0;
        end else if (load) begin
            // Load also restarts the prescaler so the next tick is a full period away.
            cnt_q <= load_val;
            rc_q  <= 1'b0;
            ps_q  <= '0;
        end else begin
            rc_q <= 1'b0;
            if (en) begin
                ps_q <= tick ? '0 : (ps_q + PS_W'(1));
                if (tick) begin
                    cnt_q <= step_val;
                    rc_q  <= wrap;
                end
            end
        end
    end

    assign cnt = cnt_q;
    assign rc  = rc_q;

endmodule

// File: tb/tb_rev_counter_n.sv
module tb_rev_counter_n;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] din;

    logic [15:0] bin_cnt, bcd_cnt, ps_cnt;
    logic        bin_tc, bcd_tc, ps_tc;
    logic        bin_rc, bcd_rc, ps_rc;

    int checks = 0;
    int errors = 0;

    rev_counter_n #(.WIDTH(16), .BCD(1'b0), .PRESCALE(1)) u_bin (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .din(din),
        .cnt(bin_cnt), .tc(bin_tc), .rc(bin_rc)
    );

    rev_counter_n #(.WIDTH(16), .BCD(1'b1), .PRESCALE(1)) u_bcd (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .din(din),
        .cnt(bcd_cnt), .tc(bcd_tc), .rc(bcd_rc)
    );

    rev_counter_n #(.WIDTH(16), .BCD(1'b0), .PRESCALE(4)) u_ps (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .din(din),
        .cnt(ps_cnt), .tc(ps_tc), .rc(ps_rc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; load = 1'b1; up = 1'b1; din = 16'h1234;
        #1;
        step(1);
        chk("rst_bin_cnt", bin_cnt, 16'h0000);
        chk("rst_bin_rc", 16'(bin_rc), 16'h0000);
        chk("rst_bcd_cnt", bcd_cnt, 16'h0000);
        chk("rst_ps_cnt", ps_cnt, 16'h0000);
        chk("rst_tc_up", 16'(bin_tc), 16'h0000);
        up = 1'b0; #1;
        chk("rst_tc_down", 16'(bin_tc), 16'h0001);

        rstn = 1'b1; load = 1'b0; up = 1'b1;
        step(1);
        chk("release_bin_cnt", bin_cnt, 16'h0001);
        chk("release_ps_hold", ps_cnt, 16'h0000);

        // Binary up wrap
        load = 1'b1; din = 16'hFFFE;
        step(1);
        chk("bup_load", bin_cnt, 16'hFFFE);
        load = 1'b0;
        step(1);
        chk("bup_ffff", bin_cnt, 16'hFFFF);
        chk("bup_ffff_tc", 16'(bin_tc), 16'h0001);
        chk("bup_ffff_rc", 16'(bin_rc), 16'h0000);
        step(1);
        chk("bup_wrap", bin_cnt, 16'h0000);
        chk("bup_wrap_rc", 16'(bin_rc), 16'h0001);
        step(1);
        chk("bup_0001", bin_cnt, 16'h0001);
        chk("bup_0001_rc", 16'(bin_rc), 16'h0000);

        // Binary down wrap and direction reversal
        load = 1'b1; din = 16'h0001; up = 1'b0;
        step(1);
        load = 1'b0;
        step(1);
        chk("bdn_0000", bin_cnt, 16'h0000);
        chk("bdn_0000_tc", 16'(bin_tc), 16'h0001);
        step(1);
        chk("bdn_wrap", bin_cnt, 16'hFFFF);
        chk("bdn_wrap_rc", 16'(bin_rc), 16'h0001);
        step(1);
        chk("bdn_fffe", bin_cnt, 16'hFFFE);
        chk("bdn_fffe_rc", 16'(bin_rc), 16'h0000);
        up = 1'b1;
        step(1);
        chk("bdir_up", bin_cnt, 16'hFFFF);
        chk("bdir_up_tc", 16'(bin_tc), 16'h0001);
        up = 1'b0;
        step(1);
        chk("bdir_down", bin_cnt, 16'hFFFE);

        // Load beats a tick
        load = 1'b1; din = 16'h0005; up = 1'b1;
        step(1);
        din = 16'h0042;
        step(1);
        chk("prio_cnt", bin_cnt, 16'h0042);
        chk("prio_rc", 16'(bin_rc), 16'h0000);

        // BCD
        din = 16'h0999;
        step(1);
        load = 1'b0;
        step(1);
        chk("bcd_up_carry", bcd_cnt, 16'h1000);
        load = 1'b1; din = 16'h9999;
        step(1);
        chk("bcd_max_tc", 16'(bcd_tc), 16'h0001);
        load = 1'b0;
        step(1);
        chk("bcd_up_wrap", bcd_cnt, 16'h0000);
        chk("bcd_up_wrap_rc", 16'(bcd_rc), 16'h0001);
        load = 1'b1; din = 16'h1000; up = 1'b0;
        step(1);
        load = 1'b0;
        step(1);
        chk("bcd_dn_borrow", bcd_cnt, 16'h0999);
        chk("bcd_dn_borrow_rc", 16'(bcd_rc), 16'h0000);
        load = 1'b1; din = 16'h0000;
        step(1);
        load = 1'b0;
        step(1);
        chk("bcd_dn_wrap", bcd_cnt, 16'h9999);
        chk("bcd_dn_wrap_rc", 16'(bcd_rc), 16'h0001);
        load = 1'b1; din = 16'h12AB;
        step(1);
        chk("bcd_sanitize", bcd_cnt, 16'h1200);

        // Prescaler = 4
        din = 16'h0000; up = 1'b1;
        step(1);
        load = 1'b0;
        step(3);
        chk("ps_pre_tick", ps_cnt, 16'h0000);
        step(1);
        chk("ps_tick1", ps_cnt, 16'h0001);
        step(4);
        chk("ps_tick2", ps_cnt, 16'h0002);
        step(1);
        en = 1'b0;
        step(2);
        en = 1'b1;
        step(2);
        chk("ps_en_hold", ps_cnt, 16'h0002);
        step(1);
        chk("ps_en_resume", ps_cnt, 16'h0003);
        step(2);
        load = 1'b1; din = 16'h0010;
        step(1);
        chk("ps_load", ps_cnt, 16'h0010);
        load = 1'b0;
        step(3);
        chk("ps_phase_hold", ps_cnt, 16'h0010);
        step(1);
        chk("ps_phase_tick", ps_cnt, 16'h0011);

        // Reset on the edge that would pulse rc
        load = 1'b1; din = 16'hFFFF; up = 1'b1;
        step(1);
        load = 1'b0; rstn = 1'b0;
        step(1);
        chk("rst_mid_cnt", bin_cnt, 16'h0000);
        chk("rst_mid_rc", 16'(bin_rc), 16'h0000);
        rstn = 1'b1;
        step(1);
        chk("rst_mid_after", bin_cnt, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
